// File: rtl/wb_pkg.sv
// Shared types for the register-file write-port arbiter: request payload and grant source.
package wb_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd_index;
    logic [XLEN-1:0]      rd_data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_LU   = 2'd2
  } gnt_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO buffering long-latency write-back results.
// Only pointers and count are reset; storage contents are don't-care when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  wb_req_t          i_push_data,
  input  logic             i_pop,
  output wb_req_t          o_head,
  output logic [CNT_W-1:0] o_count
);

  wb_req_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (i_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q] <= i_push_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the pipeline write-back path
// and buffered long-latency results, forcing a one-cycle stall on starvation.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pipe_we,
  input  logic [REG_IDX_W-1:0] i_pipe_rd_index,
  input  logic [XLEN-1:0]      i_pipe_rd_data,
  input  logic                 i_lu_valid,
  output logic                 o_lu_ready,
  input  logic [REG_IDX_W-1:0] i_lu_rd_index,
  input  logic [XLEN-1:0]      i_lu_rd_data,
  output logic                 o_pipe_stall,
  output logic                 o_rf_we,
  output logic [REG_IDX_W-1:0] o_rf_rd_index,
  output logic [XLEN-1:0]      o_rf_rd_data,
  output logic [CNT_W-1:0]     o_fifo_count
);

  wb_req_t          lu_req, fifo_head;
  wb_req_t          rf_q, rf_d;
  logic             rf_we_q, rf_we_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] fifo_count;
  gnt_src_e         gnt;
  logic             fifo_push, fifo_pop, fifo_empty, pipe_req;

  assign o_lu_ready   = fifo_count < CNT_W'(FIFO_DEPTH);
  assign o_pipe_stall = starve_q == STV_W'(STARVE_LIMIT);
  assign fifo_empty   = fifo_count == '0;
  assign lu_req       = '{rd_index: i_lu_rd_index, rd_data: i_lu_rd_data};
  // x0 results are accepted but never stored; x0 pipeline writes never claim the port.
  assign fifo_push    = i_lu_valid && o_lu_ready && (i_lu_rd_index != '0);
  assign pipe_req     = i_pipe_we && !o_pipe_stall && (i_pipe_rd_index != '0);

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (fifo_push),
    .i_push_data (lu_req),
    .i_pop       (fifo_pop),
    .o_head      (fifo_head),
    .o_count     (fifo_count)
  );

  always_comb begin
    gnt      = GNT_NONE;
    rf_we_d  = 1'b0;
    rf_d     = rf_q;
    starve_d = starve_q;
    fifo_pop = 1'b0;
    if (pipe_req)         gnt = GNT_PIPE;
    else if (!fifo_empty) gnt = GNT_LU;
    case (gnt)
      GNT_PIPE: begin
        rf_we_d = 1'b1;
        rf_d    = '{rd_index: i_pipe_rd_index, rd_data: i_pipe_rd_data};
      end
      GNT_LU: begin
        rf_we_d  = 1'b1;
        rf_d     = fifo_head;
        fifo_pop = 1'b1;
      end
      default: ;
    endcase
    // Count consecutive pipeline wins while a buffered result is waiting.
    if (fifo_empty || fifo_pop) starve_d = '0;
    else if (gnt == GNT_PIPE && starve_q != STV_W'(STARVE_LIMIT))
      starve_d = starve_q + STV_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rf_we_q  <= 1'b0;
      rf_q     <= '0;
      starve_q <= '0;
    end else begin
      rf_we_q  <= rf_we_d;
      rf_q     <= rf_d;
      starve_q <= starve_d;
    end
  end

  assign o_rf_we       = rf_we_q;
  assign o_rf_rd_index = rf_q.rd_index;
  assign o_rf_rd_data  = rf_q.rd_data;
  assign o_fifo_count  = fifo_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_idx = '0;
  logic [63:0] pipe_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_idx = '0;
  logic [63:0] lu_data = '0;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_idx;
  logic [63:0] rf_data;
  logic [1:0]  fifo_count;

  int tests = 0;
  int fails = 0;
  int exp_idx [16];

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_pipe_we       (pipe_we),
    .i_pipe_rd_index (pipe_idx),
    .i_pipe_rd_data  (pipe_data),
    .i_lu_valid      (lu_valid),
    .o_lu_ready      (lu_ready),
    .i_lu_rd_index   (lu_idx),
    .i_lu_rd_data    (lu_data),
    .o_pipe_stall    (pipe_stall),
    .o_rf_we         (rf_we),
    .o_rf_rd_index   (rf_idx),
    .o_rf_rd_data    (rf_data),
    .o_fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic we, input logic [4:0] idx, input logic [63:0] d);
    pipe_we = we; pipe_idx = idx; pipe_data = d;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] idx, input logic [63:0] d);
    lu_valid = v; lu_idx = idx; lu_data = d;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (rf_we !== 1'b0 || rf_idx !== 5'd0 || rf_data !== 64'd0) begin
      fails++; $display("FAIL reset_rf: we=%b idx=%0d data=%h, expected 0/0/0", rf_we, rf_idx, rf_data);
    end
    tests++; if (fifo_count !== 2'd0 || lu_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      fails++; $display("FAIL reset_ctl: count=%0d ready=%b stall=%b, expected 0/1/0", fifo_count, lu_ready, pipe_stall);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pipe_only();
    set_pipe(1'b1, 5'd5, 64'hDEAD_BEEF);
    tick();
    tests++; if (rf_we !== 1'b1 || rf_idx !== 5'd5 || rf_data !== 64'hDEAD_BEEF) begin
      fails++; $display("FAIL pipe_write: we=%b idx=%0d data=%h, expected 1/5/deadbeef", rf_we, rf_idx, rf_data);
    end
    set_pipe(1'b0, 5'd6, 64'h0);
    tick();
    tests++; if (rf_we !== 1'b0 || rf_idx !== 5'd5 || rf_data !== 64'hDEAD_BEEF) begin
      fails++; $display("FAIL pipe_idle_hold: we=%b idx=%0d data=%h, expected 0/5/deadbeef", rf_we, rf_idx, rf_data);
    end
  endtask

  task automatic test_lu_only();
    set_lu(1'b1, 5'd7, 64'h1234);
    tick();
    set_lu(1'b0, 5'd0, 64'h0);
    tests++; if (fifo_count !== 2'd1 || rf_we !== 1'b0) begin
      fails++; $display("FAIL lu_enqueue: count=%0d we=%b, expected 1/0", fifo_count, rf_we);
    end
    tick();
    tests++; if (rf_we !== 1'b1 || rf_idx !== 5'd7 || rf_data !== 64'h1234 || fifo_count !== 2'd0) begin
      fails++; $display("FAIL lu_pop: we=%b idx=%0d data=%h count=%0d, expected 1/7/1234/0", rf_we, rf_idx, rf_data, fifo_count);
    end
    tick();
    tests++; if (rf_we !== 1'b0) begin
      fails++; $display("FAIL lu_after: we=%b, expected 0", rf_we);
    end
  endtask

  task automatic test_starvation();
    set_pipe(1'b1, 5'd8, 64'h80);
    set_lu(1'b1, 5'd9, 64'h99);
    tick();
    set_lu(1'b0, 5'd0, 64'h0);
    tests++; if (rf_idx !== 5'd8 || fifo_count !== 2'd1 || pipe_stall !== 1'b0) begin
      fails++; $display("FAIL starve_setup: idx=%0d count=%0d stall=%b, expected 8/1/0", rf_idx, fifo_count, pipe_stall);
    end
    for (int i = 1; i <= 4; i++) begin
      set_pipe(1'b1, 5'(i), 64'h100 + 64'(i));
      tick();
      tests++; if (rf_we !== 1'b1 || rf_idx !== 5'(i) || pipe_stall !== (i == 4)) begin
        fails++; $display("FAIL starve_pipe%0d: we=%b idx=%0d stall=%b, expected 1/%0d/%b", i, rf_we, rf_idx, pipe_stall, i, (i == 4));
      end
    end
    set_pipe(1'b1, 5'd5, 64'h105);
    tick();
    tests++; if (rf_we !== 1'b1 || rf_idx !== 5'd9 || rf_data !== 64'h99 || pipe_stall !== 1'b0 || fifo_count !== 2'd0) begin
      fails++; $display("FAIL starve_drain: we=%b idx=%0d data=%h stall=%b count=%0d, expected 1/9/99/0/0", rf_we, rf_idx, rf_data, pipe_stall, fifo_count);
    end
    tick();
    tests++; if (rf_we !== 1'b1 || rf_idx !== 5'd5 || rf_data !== 64'h105) begin
      fails++; $display("FAIL starve_held_write: we=%b idx=%0d data=%h, expected 1/5/105", rf_we, rf_idx, rf_data);
    end
    set_pipe(1'b0, 5'd0, 64'h0);
    tick();
  endtask

  task automatic test_x0();
    set_pipe(1'b1, 5'd1, 64'h11);
    set_lu(1'b1, 5'd3, 64'h33);
    tick();
    set_lu(1'b0, 5'd0, 64'h0);
    set_pipe(1'b1, 5'd0, 64'hFF);
    tick();
    tests++; if (rf_we !== 1'b1 || rf_idx !== 5'd3 || rf_data !== 64'h33 || fifo_count !== 2'd0) begin
      fails++; $display("FAIL x0_pipe_slot: we=%b idx=%0d data=%h count=%0d, expected 1/3/33/0", rf_we, rf_idx, rf_data, fifo_count);
    end
    set_pipe(1'b0, 5'd0, 64'h0);
    set_lu(1'b1, 5'd0, 64'h77);
    tick();
    set_lu(1'b0, 5'd0, 64'h0);
    tests++; if (fifo_count !== 2'd0 || rf_we !== 1'b0 || rf_idx !== 5'd3 || lu_ready !== 1'b1) begin
      fails++; $display("FAIL x0_lu_drop: count=%0d we=%b idx=%0d ready=%b, expected 0/0/3/1", fifo_count, rf_we, rf_idx, lu_ready);
    end
    set_pipe(1'b1, 5'd0, 64'h55);
    tick();
    tests++; if (rf_we !== 1'b0 || rf_data !== 64'h33) begin
      fails++; $display("FAIL x0_pipe_nowrite: we=%b data=%h, expected 0/33", rf_we, rf_data);
    end
    set_pipe(1'b0, 5'd0, 64'h0);
  endtask

  task automatic test_full_fifo();
    int k = 0;
    int n = 0;
    logic acc, stl;
    exp_idx = '{1, 2, 3, 4, 5, 20, 6, 7, 8, 9, 21, 10, 11, 12, 13, 22};
    for (int c = 0; c < 16; c++) begin
      set_pipe(1'b1, 5'(k + 1), 64'hA00 + 64'(k));
      if (n < 3) set_lu(1'b1, 5'(20 + n), 64'hB00 + 64'(n));
      else       set_lu(1'b0, 5'd0, 64'h0);
      acc = (n < 3) && lu_ready;
      stl = pipe_stall;
      tick();
      if (acc) n++;
      if (!stl) k++;
      tests++; if (rf_we !== 1'b1 || rf_idx !== 5'(exp_idx[c])) begin
        fails++; $display("FAIL full_fifo_cycle%0d: we=%b idx=%0d, expected 1/%0d", c, rf_we, rf_idx, exp_idx[c]);
      end
      if (c == 1) begin
        tests++; if (fifo_count !== 2'd2 || lu_ready !== 1'b0) begin
          fails++; $display("FAIL full_fifo_ready: count=%0d ready=%b, expected 2/0", fifo_count, lu_ready);
        end
      end
      if (c == 15) begin
        tests++; if (rf_data !== 64'hB02 || n != 3) begin
          fails++; $display("FAIL full_fifo_last: data=%h accepted=%0d, expected b02/3", rf_data, n);
        end
      end
    end
    set_pipe(1'b0, 5'd0, 64'h0);
    set_lu(1'b0, 5'd0, 64'h0);
    tick();
    tests++; if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
      fails++; $display("FAIL full_fifo_idle: we=%b count=%0d, expected 0/0", rf_we, fifo_count);
    end
  endtask

  task automatic test_reset_mid();
    set_pipe(1'b1, 5'd1, 64'h1);
    set_lu(1'b1, 5'd20, 64'h20);
    tick();
    set_pipe(1'b1, 5'd2, 64'h2);
    set_lu(1'b1, 5'd21, 64'h21);
    tick();
    set_lu(1'b0, 5'd0, 64'h0);
    set_pipe(1'b1, 5'd3, 64'h3);
    tests++; if (fifo_count !== 2'd2) begin
      fails++; $display("FAIL reset_mid_setup: count=%0d, expected 2", fifo_count);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (rf_we !== 1'b0 || fifo_count !== 2'd0 || lu_ready !== 1'b1 || pipe_stall !== 1'b0) begin
      fails++; $display("FAIL reset_mid: we=%b count=%0d ready=%b stall=%b, expected 0/0/1/0", rf_we, fifo_count, lu_ready, pipe_stall);
    end
    set_pipe(1'b0, 5'd0, 64'h0);
    #2 rst_n = 1'b1;
    tick();
    tests++; if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
      fails++; $display("FAIL reset_mid_stale1: we=%b count=%0d, expected 0/0", rf_we, fifo_count);
    end
    tick();
    tests++; if (rf_we !== 1'b0) begin
      fails++; $display("FAIL reset_mid_stale2: we=%b, expected 0", rf_we);
    end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_lu_only();
    test_starvation();
    test_x0();
    test_full_fifo();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
